fos_iir_mc: RTL and testbench
=============================

Name: fos_iir_mc

Overview:
- Parametrised, multi-channel, time-multiplexed first-order IIR section computing y[n] = u[n] − ((a1·y[n−1]) >>> FRAC).
  - Delay mode: u[n] = x[n−1].
  - Direct mode: u[n] = x[n].
- Successor to the single-channel fixed-32-bit first-order section.
- Adds:
  - configurable data width, coefficient width and fixed-point shift;
  - per-channel state and coefficients;
  - an iterative radix-4 Booth multiplier behind a valid/ready handshake;
  - output saturation.
- Sits in the filter datapath between sample sources and downstream accumulators.

Parameters:
- DW, 32, sample/output width (signed).
- CW, 11, coefficient width (signed).
- FRAC, 0, arithmetic right shift applied to the product (coefficient fractional bits).
- CH, 4, number of channels (≥1).
- CHW, $clog2(CH) (min 1), channel index width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 on a clk edge resets the block).
- in_valid  in  1  sample offered.
- in_ready  out  1  block idle, can accept.
- x_in  in  DW  signed input sample.
- ch_in  in  CHW  channel of x_in.
- delay_en  in  1  1 = delay mode (u = x[n−1]), 0 = direct mode (u = x[n]); sampled at accept.
- coef_we  in  1  coefficient write strobe.
- coef_ch  in  CHW  coefficient channel.
- coef_data  in  CW  signed a1 value.
- out_valid  out  1  one-cycle pulse, y_out/ch_out valid.
- y_out  out  DW  signed saturated result.
- ch_out  out  CHW  channel of y_out.

Behaviour:
- Reset (reset==0):
  - FSM → IDLE.
  - All per-channel x_prev, y_prev and a1 cleared to 0.
  - out_valid=0, y_out=0, ch_out=0, in_ready=0 during the reset cycle.
  - Reset mid-multiply aborts the operation: no out_valid, no state update.
- FSM states IDLE → MUL → DONE → IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch x_in, ch_in and delay_en.
  - Also latch a1[ch], y_prev[ch] and x_prev[ch] into operand registers.
  - Go to MUL.
- MUL:
  - in_ready=0.
  - Radix-4 Booth iterative multiply of a1 (CW) × y_prev (DW).
  - NITER = (CW+1)/2 cycles (integer division); 6 for CW=11.
  - Partial-product accumulator is DW+CW+2 bits, signed.
  - After NITER cycles go to DONE.
- DONE:
  - p = full product >>> FRAC (arithmetic).
  - s = u − p, computed at DW+CW+2 bits.
  - Saturate s to [−2^(DW−1), 2^(DW−1)−1].
  - Register y_out=sat(s), ch_out=ch, out_valid=1 for exactly one cycle.
  - Write y_prev[ch]=sat(s) and x_prev[ch]=latched x_in (in both modes).
  - Return to IDLE.
- Latency: accept edge → out_valid high after NITER+1 further edges.
  - Throughput: one sample per NITER+2 cycles.
  - in_ready is high again in the cycle out_valid is high.
- y_out and ch_out hold their last value between pulses.
- Coefficient writes:
  - Accepted in any state, effective on the next edge.
  - A write to the channel in flight does not affect the current computation (operand already latched); it applies from the next sample.
  - A write coincident with accept of the same channel: the accepted sample uses the OLD a1.
- ch_in ≥ CH or coef_ch ≥ CH: sample/write ignored, no out_valid, in_ready unaffected.
- in_valid while in_ready=0: not accepted; the source must hold the sample.
- Channels are fully independent: no state crosstalk.

Decomposition:
- Package fos_pkg:
  - FSM state enum (ST_IDLE, ST_MUL, ST_DONE);
  - Booth digit decode function;
  - saturation function;
  - NITER helper.
- Sub-module booth_r4_seq: start/busy/done iterative signed multiplier, parametrised DW and CW.
  - The top holds the FSM, channel state arrays, the coefficient RAM and the output register.

Test Plan:
- Default params (FRAC=0), ch0 a1=0, delay_en=1, x=5,7,9 → y=0,5,7; each out_valid exactly 7 cycles after accept.
- ch0 a1=1, delay_en=1, x=10,0,0,0 → y=0,10,−10,10.
- DW=16, FRAC=0, a1=−2, delay_en=0:
  - x=30000 → y=30000;
  - then x=0 → 32767 (saturated);
  - then x=0 → 32767.
- FRAC=8, a1=128, delay_en=1, x=256,0,0,0,0 → y=0,256,−128,64,−32.
- Interleaving:
  - ch1 a1=1 fed 100,0 and ch2 a1=0 fed 50,0, interleaved, delay_en=1;
  - → ch1 0,100 and ch2 0,50; ch_out matches each sample.
- Robustness:
  - coef_we to ch0 during MUL → current result uses the old a1.
  - reset=0 asserted mid-MUL → no out_valid; all y_prev=0; next sample behaves as from power-up.

Source files
------------

// File: rtl/fos_pkg.sv
// Shared types and helpers for the multi-channel first-order IIR section:
// FSM states, radix-4 Booth digit recoding, saturation and iteration count.
package fos_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DONE
   } state_t;

   // Wide enough for any sensible DW+CW+2 intermediate.
   localparam int SAT_W = 128;

   function automatic int niter(input int cw);
      return (cw + 1) / 2;
   endfunction

   // Bits are {q[2i+1], q[2i], q[2i-1]}; result is the digit in -2..+2.
   function automatic logic signed [2:0] booth_digit(input logic [2:0] g);
      logic signed [2:0] d;
      case (g)
         3'b001, 3'b010: d = 3'sb001;
         3'b011:         d = 3'sb010;
         3'b100:         d = 3'sb110;
         3'b101, 3'b110: d = 3'sb111;
         default:        d = 3'sb000;
      endcase
      return d;
   endfunction

   function automatic logic signed [SAT_W-1:0] sat_val(input logic signed [SAT_W-1:0] s,
                                                       input int dw);
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (SAT_W'(1) << (dw - 1)) - SAT_W'(1);
      lo = ~hi;
      if (s > hi) return hi;
      if (s < lo) return lo;
      return s;
   endfunction

endpackage

// File: rtl/booth_r4_seq.sv
// Iterative signed radix-4 Booth multiplier: one Booth digit per cycle,
// operands captured on start, product valid the edge after done.
module booth_r4_seq
   import fos_pkg::*;
#(
   parameter int DW = 32,
   parameter int CW = 11
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic signed [CW-1:0]       a_in,
   input  logic signed [DW-1:0]       b_in,
   output logic                       busy,
   output logic                       done,
   output logic signed [DW+CW+1:0]    prod
);

   localparam int AW    = DW + CW + 2;
   localparam int NITER = niter(CW);
   localparam int CNTW  = $clog2(NITER + 1);

   logic                  busy_q, busy_d;
   logic [CNTW-1:0]       cnt_q, cnt_d;
   logic [CW:0]           mplr_q, mplr_d;
   logic signed [AW-1:0]  mcand_q, mcand_d;
   logic signed [AW-1:0]  acc_q, acc_d;
   logic signed [2:0]     digit;
   logic signed [AW-1:0]  pp;
   logic                  last;

   always_comb begin
      digit = booth_digit(mplr_q[2:0]);
      case (digit)
         3'sb001: pp = mcand_q;
         3'sb010: pp = mcand_q <<< 1;
         3'sb111: pp = -mcand_q;
         3'sb110: pp = -(mcand_q <<< 1);
         default: pp = '0;
      endcase

      last    = busy_q && (cnt_q == CNTW'(NITER - 1));
      busy_d  = busy_q;
      cnt_d   = cnt_q;
      mplr_d  = mplr_q;
      mcand_d = mcand_q;
      acc_d   = acc_q;

      if (start) begin
         busy_d  = 1'b1;
         cnt_d   = '0;
         mplr_d  = {a_in, 1'b0};
         mcand_d = {{(AW - DW){b_in[DW-1]}}, b_in};
         acc_d   = '0;
      end else if (busy_q) begin
         // Multiplier shifts right by one digit, multiplicand left by one digit weight.
         acc_d   = acc_q + pp;
         mplr_d  = {{2{mplr_q[CW]}}, mplr_q[CW:2]};
         mcand_d = mcand_q <<< 2;
         cnt_d   = cnt_q + 1'b1;
         if (last) busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      mplr_q  <= mplr_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
   end

   assign busy = busy_q;
   assign done = last;
   assign prod = acc_q;

endmodule

// File: rtl/fos_iir_mc.sv
// Time-multiplexed multi-channel first-order IIR: y = u - ((a1*y_prev) >>> FRAC),
// u = x[n-1] (delay mode) or x[n] (direct mode), result saturated to DW bits.
module fos_iir_mc
   import fos_pkg::*;
#(
   parameter int DW   = 32,
   parameter int CW   = 11,
   parameter int FRAC = 0,
   parameter int CH   = 4,
   parameter int CHW  = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic signed [DW-1:0]  x_in,
   input  logic [CHW-1:0]        ch_in,
   input  logic                  delay_en,
   input  logic                  coef_we,
   input  logic [CHW-1:0]        coef_ch,
   input  logic signed [CW-1:0]  coef_data,
   output logic                  out_valid,
   output logic signed [DW-1:0]  y_out,
   output logic [CHW-1:0]        ch_out
);

   localparam int AW = DW + CW + 2;

   state_t                state_q, state_d;
   logic [CHW-1:0]        ch_q, ch_d;
   logic                  dly_q, dly_d;
   logic signed [DW-1:0]  x_q, x_d;
   logic signed [DW-1:0]  xp_q, xp_d;

   logic signed [CW-1:0]  a1_q[CH], a1_d[CH];
   logic signed [DW-1:0]  yprev_q[CH], yprev_d[CH];
   logic signed [DW-1:0]  xprev_q[CH], xprev_d[CH];

   logic                  out_valid_q, out_valid_d;
   logic signed [DW-1:0]  y_out_q, y_out_d;
   logic [CHW-1:0]        ch_out_q, ch_out_d;

   logic                  ch_ok, cw_ok, accept, start;
   logic                  mul_busy, mul_done;
   logic signed [AW-1:0]  prod;
   logic signed [DW-1:0]  x_sel;
   logic signed [AW-1:0]  u_ext, p_shr, s_diff;
   logic signed [SAT_W-1:0] s_wide;
   logic signed [DW-1:0]  y_new;

   assign ch_ok    = {1'b0, ch_in}   < (CHW + 1)'(CH);
   assign cw_ok    = {1'b0, coef_ch} < (CHW + 1)'(CH);
   assign in_ready = reset && (state_q == ST_IDLE) && !mul_busy;
   assign accept   = in_valid && in_ready && ch_ok;
   assign start    = accept;

   // Coefficient and feedback state are captured by the multiplier at accept.
   booth_r4_seq #(.DW(DW), .CW(CW)) u_mul (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .a_in  (a1_q[ch_in]),
      .b_in  (yprev_q[ch_in]),
      .busy  (mul_busy),
      .done  (mul_done),
      .prod  (prod)
   );

   always_comb begin
      x_sel  = dly_q ? xp_q : x_q;
      u_ext  = {{(AW - DW){x_sel[DW-1]}}, x_sel};
      p_shr  = prod >>> FRAC;
      s_diff = u_ext - p_shr;
      s_wide = s_diff;
      y_new  = DW'(sat_val(s_wide, DW));

      state_d     = state_q;
      ch_d        = ch_q;
      dly_d       = dly_q;
      x_d         = x_q;
      xp_d        = xp_q;
      a1_d        = a1_q;
      yprev_d     = yprev_q;
      xprev_d     = xprev_q;
      out_valid_d = 1'b0;
      y_out_d     = y_out_q;
      ch_out_d    = ch_out_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_MUL;
               ch_d    = ch_in;
               dly_d   = delay_en;
               x_d     = x_in;
               xp_d    = xprev_q[ch_in];
            end
         end
         ST_MUL: begin
            if (mul_done) state_d = ST_DONE;
         end
         ST_DONE: begin
            out_valid_d    = 1'b1;
            y_out_d        = y_new;
            ch_out_d       = ch_q;
            yprev_d[ch_q]  = y_new;
            xprev_d[ch_q]  = x_q;
            state_d        = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (coef_we && cw_ok) a1_d[coef_ch] = coef_data;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         y_out_q     <= '0;
         ch_out_q    <= '0;
         for (int i = 0; i < CH; i++) begin
            a1_q[i]    <= '0;
            yprev_q[i] <= '0;
            xprev_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         y_out_q     <= y_out_d;
         ch_out_q    <= ch_out_d;
         a1_q        <= a1_d;
         yprev_q     <= yprev_d;
         xprev_q     <= xprev_d;
      end
   end

   always_ff @(posedge clk) begin
      ch_q  <= ch_d;
      dly_q <= dly_d;
      x_q   <= x_d;
      xp_q  <= xp_d;
   end

   assign out_valid = out_valid_q;
   assign y_out     = y_out_q;
   assign ch_out    = ch_out_q;

endmodule

// File: tb/tb_fos_iir_mc.sv
// Bench for fos_iir_mc: directed cases plus random traffic on two instances
// (32-bit FRAC=0 and 16-bit FRAC=8) against a plain-arithmetic reference.
module tb_fos_iir_mc;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               iv_a = 1'b0, iv_b = 1'b0;
   logic               cwe_a = 1'b0, cwe_b = 1'b0;
   logic [1:0]         ch_in = '0, coef_ch = '0;
   logic               dly = 1'b0;
   logic signed [10:0] coef_data = '0;
   logic signed [31:0] x_a = '0;
   logic signed [15:0] x_b = '0;
   logic               rdy_a, rdy_b, ov_a, ov_b;
   logic signed [31:0] y_a;
   logic signed [15:0] y_b;
   logic [1:0]         cho_a, cho_b;

   int n_cmp = 0;
   int n_err = 0;

   longint m_a1[2][4];
   longint m_y[2][4];
   longint m_x[2][4];
   longint y_obs;

   always #5 clk = ~clk;

   fos_iir_mc #(.DW(32), .CW(11), .FRAC(0), .CH(4)) u_dut_a (
      .clk(clk), .reset(rst_n), .in_valid(iv_a), .in_ready(rdy_a), .x_in(x_a),
      .ch_in(ch_in), .delay_en(dly), .coef_we(cwe_a), .coef_ch(coef_ch),
      .coef_data(coef_data), .out_valid(ov_a), .y_out(y_a), .ch_out(cho_a));

   fos_iir_mc #(.DW(16), .CW(11), .FRAC(8), .CH(4)) u_dut_b (
      .clk(clk), .reset(rst_n), .in_valid(iv_b), .in_ready(rdy_b), .x_in(x_b),
      .ch_in(ch_in), .delay_en(dly), .coef_we(cwe_b), .coef_ch(coef_ch),
      .coef_data(coef_data), .out_valid(ov_b), .y_out(y_b), .ch_out(cho_b));

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check_val(input string tag, input longint obs, input longint exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic longint get_y(input int d);
      return (d != 0) ? longint'(y_b) : longint'(y_a);
   endfunction
   function automatic longint get_ov(input int d);
      return (d != 0) ? longint'(ov_b) : longint'(ov_a);
   endfunction
   function automatic longint get_rdy(input int d);
      return (d != 0) ? longint'(rdy_b) : longint'(rdy_a);
   endfunction
   function automatic longint get_ch(input int d);
      return (d != 0) ? longint'(cho_b) : longint'(cho_a);
   endfunction

   function automatic longint norm(input int d, input longint x);
      logic signed [15:0] s16;
      logic signed [31:0] s32;
      s16 = x[15:0];
      s32 = x[31:0];
      return (d != 0) ? longint'(s16) : longint'(s32);
   endfunction

   // Reference: y = u - ((a1*y_prev) >>> frac), clamped to the instance width.
   function automatic longint model_step(input int d, input int ch, input longint x, input bit de);
      longint p, u, s, hi, lo;
      int     dw, fr;
      dw = (d != 0) ? 16 : 32;
      fr = (d != 0) ? 8 : 0;
      p  = (m_a1[d][ch] * m_y[d][ch]) >>> fr;
      u  = de ? m_x[d][ch] : x;
      s  = u - p;
      hi = (64'sd1 <<< (dw - 1)) - 1;
      lo = -hi - 1;
      if (s > hi) s = hi;
      if (s < lo) s = lo;
      m_y[d][ch] = s;
      m_x[d][ch] = x;
      return s;
   endfunction

   function automatic void model_clear();
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < 4; c++) begin
            m_a1[d][c] = 0;
            m_y[d][c]  = 0;
            m_x[d][c]  = 0;
         end
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      check_val("rst_rdy_a", rdy_a, 0);
      check_val("rst_rdy_b", rdy_b, 0);
      check_val("rst_ov_a", ov_a, 0);
      check_val("rst_y_a", y_a, 0);
      check_val("rst_ch_a", cho_a, 0);
      check_val("rst_y_b", y_b, 0);
      rst_n = 1'b1;
      model_clear();
   endtask

   task automatic coef_wr(input int d, input int ch, input longint v);
      coef_ch   = ch[1:0];
      coef_data = v[10:0];
      if (d == 0) cwe_a = 1'b1; else cwe_b = 1'b1;
      @(posedge clk); #1;
      cwe_a = 1'b0;
      cwe_b = 1'b0;
      m_a1[d][ch] = v;
   endtask

   // One sample end to end; optionally rewrites the same channel's a1 mid-multiply.
   task automatic send(input int d, input int ch, input longint x_raw, input bit de,
                       input bit mid, input longint mid_coef, output longint yo);
      longint x, y_exp;
      int     n, lat;
      bit     seen;
      x = norm(d, x_raw);
      n = 0;
      while (get_rdy(d) == 0 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check_val("ready_before_send", get_rdy(d), 1);
      ch_in = ch[1:0];
      dly   = de;
      x_a   = x[31:0];
      x_b   = x[15:0];
      if (d == 0) iv_a = 1'b1; else iv_b = 1'b1;
      @(posedge clk); #1;
      iv_a  = 1'b0;
      iv_b  = 1'b0;
      y_exp = model_step(d, ch, x, de);
      lat   = 0;
      seen  = 1'b0;
      while (!seen && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (mid && lat == 2) begin
            coef_ch   = ch[1:0];
            coef_data = mid_coef[10:0];
            if (d == 0) cwe_a = 1'b1; else cwe_b = 1'b1;
         end
         if (mid && lat == 3) begin
            cwe_a = 1'b0;
            cwe_b = 1'b0;
            m_a1[d][ch] = mid_coef;
         end
         seen = (get_ov(d) != 0);
      end
      check_val("latency", lat, 7);
      check_val("y_out", get_y(d), y_exp);
      check_val("ch_out", get_ch(d), ch);
      check_val("ready_with_ov", get_rdy(d), 1);
      yo = get_y(d);
      @(posedge clk); #1;
      check_val("ov_pulse", get_ov(d), 0);
      check_val("y_hold", get_y(d), y_exp);
   endtask

   initial begin
      int     ovc, d, ch;
      longint x, cv;
      bit     de;
      logic signed [10:0] c11;

      model_clear();
      repeat (3) @(posedge clk);
      #1;
      check_val("init_rdy", rdy_a, 0);
      check_val("init_ov", ov_a, 0);
      check_val("init_y", y_a, 0);
      rst_n = 1'b1;

      // a1 = 0 in delay mode: output is the previous input
      send(0, 0, 5, 1, 0, 0, y_obs); check_val("tp1_0", y_obs, 0);
      send(0, 0, 7, 1, 0, 0, y_obs); check_val("tp1_1", y_obs, 5);
      send(0, 0, 9, 1, 0, 0, y_obs); check_val("tp1_2", y_obs, 7);

      do_reset();
      coef_wr(0, 0, 1);
      send(0, 0, 10, 1, 0, 0, y_obs); check_val("tp2_0", y_obs, 0);
      send(0, 0, 0, 1, 0, 0, y_obs);  check_val("tp2_1", y_obs, 10);
      send(0, 0, 0, 1, 0, 0, y_obs);  check_val("tp2_2", y_obs, -10);
      send(0, 0, 0, 1, 0, 0, y_obs);  check_val("tp2_3", y_obs, 10);

      // 16-bit instance, a1 = -512 with 8 fractional bits is -2.0
      coef_wr(1, 0, -512);
      send(1, 0, 30000, 0, 0, 0, y_obs); check_val("tp3_0", y_obs, 30000);
      send(1, 0, 0, 0, 0, 0, y_obs);     check_val("tp3_1", y_obs, 32767);
      send(1, 0, 0, 0, 0, 0, y_obs);     check_val("tp3_2", y_obs, 32767);

      coef_wr(1, 1, 128);
      send(1, 1, 256, 1, 0, 0, y_obs); check_val("tp4_0", y_obs, 0);
      send(1, 1, 0, 1, 0, 0, y_obs);   check_val("tp4_1", y_obs, 256);
      send(1, 1, 0, 1, 0, 0, y_obs);   check_val("tp4_2", y_obs, -128);
      send(1, 1, 0, 1, 0, 0, y_obs);   check_val("tp4_3", y_obs, 64);
      send(1, 1, 0, 1, 0, 0, y_obs);   check_val("tp4_4", y_obs, -32);

      do_reset();
      coef_wr(0, 1, 1);
      coef_wr(0, 2, 0);
      send(0, 1, 100, 1, 0, 0, y_obs); check_val("tp5_c1a", y_obs, 0);
      send(0, 2, 50, 1, 0, 0, y_obs);  check_val("tp5_c2a", y_obs, 0);
      send(0, 1, 0, 1, 0, 0, y_obs);   check_val("tp5_c1b", y_obs, 100);
      send(0, 2, 0, 1, 0, 0, y_obs);   check_val("tp5_c2b", y_obs, 50);

      // coefficient rewrite while multiplying applies only to the next sample
      do_reset();
      coef_wr(0, 0, 1);
      send(0, 0, 10, 1, 0, 0, y_obs);
      send(0, 0, 0, 1, 0, 0, y_obs);
      send(0, 0, 0, 1, 1, 3, y_obs); check_val("mid_coef_old", y_obs, -10);
      send(0, 0, 0, 1, 0, 0, y_obs); check_val("mid_coef_new", y_obs, 30);

      // reset in the middle of a multiply
      coef_wr(0, 1, 1);
      send(0, 1, 40, 1, 0, 0, y_obs);
      send(0, 1, 60, 1, 0, 0, y_obs); check_val("pre_rst_c1", y_obs, 40);
      ch_in = 2'd0; x_a = 32'sd9; dly = 1'b1; iv_a = 1'b1;
      @(posedge clk); #1;
      iv_a = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check_val("midrst_rdy", rdy_a, 0);
      rst_n = 1'b1;
      model_clear();
      ovc = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (ov_a) ovc++;
      end
      check_val("midrst_no_ov", ovc, 0);
      send(0, 0, 7, 1, 0, 0, y_obs); check_val("post_rst_0", y_obs, 0);
      send(0, 0, 0, 1, 0, 0, y_obs); check_val("post_rst_1", y_obs, 7);
      coef_wr(0, 1, 1);
      send(0, 1, 0, 1, 0, 0, y_obs); check_val("post_rst_c1", y_obs, 0);

      // random traffic across both instances and all channels
      for (int i = 0; i < 80; i++) begin
         d  = int'($urandom_range(0, 1));
         ch = int'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) begin
            c11 = 11'($urandom);
            cv  = longint'(c11);
            coef_wr(d, ch, cv);
         end
         x = longint'($urandom);
         if ($urandom_range(0, 1) == 0) x = x % 2000;
         de = 1'($urandom_range(0, 1));
         send(d, ch, x, de, 0, 0, y_obs);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
